// File: rtl/rotor_step_sequencer.sv
// rtl/rotor_step_sequencer.sv - keypad/config sequencer for the rotor-position block (optional DOUBLE_STEP_EN)
module rotor_step_sequencer #(
  parameter int SETTLE_CYC = 2,
  parameter int NOTCH2     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [4:0] cfg_pos1,
  input  logic [4:0] cfg_pos2,
  input  logic [4:0] cfg_pos3,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       enc_valid,
  output logic       busy,
  output logic [4:0] rp_rnotch,
  output logic [1:0] rp_sel,
  output logic       rp_ld,
  output logic       rp_step,
  input  logic [4:0] r1,
  input  logic [4:0] r2,
  input  logic [4:0] r3
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_CLR,
    S_CFG_LD1,
    S_CFG_LD2,
    S_CFG_LD3,
    S_STEP,
`ifdef DOUBLE_STEP_EN
    S_DS_LD2,
    S_DS_LD3,
`endif
    S_SETTLE,
    S_ENC
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_HI, PH_LO} phase_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  state_t     state, next_state, after_action;
  phase_t     phase, next_phase;
  logic [7:0] settle_cnt;
  logic       ready_en;
  logic       is_action;
  logic       cfg_accept, key_accept;
  logic [4:0] pos1, pos2, pos3;

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p >= 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic [4:0] clamp26(input logic [4:0] p);
    return (p > 5'd25) ? 5'd0 : p;
  endfunction

`ifdef DOUBLE_STEP_EN
  logic       ds;
  logic [4:0] r2_pre, ds_pos2, ds_pos3;
  logic       unused_fb;
  assign unused_fb = ^r1;
`else
  logic       unused_fb;
  assign unused_fb = ^{r1, r2, r3, 5'(NOTCH2)};
`endif

  // ready_en keeps both ready outputs low until the first clock after reset release
  assign cfg_ready  = ready_en && (state == S_IDLE);
  assign key_ready  = cfg_ready && !cfg_valid;
  assign cfg_accept = cfg_valid && cfg_ready;
  assign key_accept = key_valid && key_ready;
  assign busy       = (state != S_IDLE);

  // State, phase, settle counter and captured load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      phase      <= PH_SETUP;
      settle_cnt <= '0;
      ready_en   <= 1'b0;
      pos1       <= '0;
      pos2       <= '0;
      pos3       <= '0;
`ifdef DOUBLE_STEP_EN
      ds         <= 1'b0;
      r2_pre     <= '0;
      ds_pos2    <= '0;
      ds_pos3    <= '0;
`endif
    end else begin
      state    <= next_state;
      phase    <= next_phase;
      ready_en <= 1'b1;
      if (cfg_accept) begin
        pos1 <= clamp26(cfg_pos1);
        pos2 <= clamp26(cfg_pos2);
        pos3 <= clamp26(cfg_pos3);
      end
      if (next_state == S_SETTLE && state != S_SETTLE) begin
        settle_cnt <= SETTLE_LOAD;
      end else if (state == S_SETTLE && settle_cnt != 8'd0) begin
        settle_cnt <= settle_cnt - 8'd1;
      end
`ifdef DOUBLE_STEP_EN
      if (key_accept) begin
        r2_pre <= r2;
        ds     <= (r2 == 5'(NOTCH2));
      end
      // Capture the double-step targets once the STEP has settled, so load data
      // cannot move while a later strobe is high.
      if (state == S_STEP && phase == PH_LO) begin
        ds_pos2 <= inc26(r2);
        ds_pos3 <= inc26(r3);
      end
`endif
    end
  end

  // Next-state decode and rotor interface drive
  always_comb begin
    next_state   = state;
    next_phase   = phase;
    after_action = state;
    is_action    = 1'b0;
    rp_sel       = 2'd0;
    rp_rnotch    = 5'd0;
    rp_ld        = 1'b0;
    rp_step      = 1'b0;
    enc_valid    = 1'b0;
    case (state)
      S_CFG_CLR: begin
        is_action    = 1'b1;
        after_action = S_CFG_LD1;
      end
      S_CFG_LD1: begin
        is_action    = 1'b1;
        rp_sel       = 2'd1;
        rp_rnotch    = pos1;
        after_action = S_CFG_LD2;
      end
      S_CFG_LD2: begin
        is_action    = 1'b1;
        rp_sel       = 2'd2;
        rp_rnotch    = pos2;
        after_action = S_CFG_LD3;
      end
      S_CFG_LD3: begin
        is_action    = 1'b1;
        rp_sel       = 2'd3;
        rp_rnotch    = pos3;
        after_action = S_IDLE;
      end
      S_STEP: begin
        is_action    = 1'b1;
        after_action = S_SETTLE;
`ifdef DOUBLE_STEP_EN
        // Skip the R2 load when the block's own carry already advanced R2
        if (ds) after_action = (r2 == r2_pre) ? S_DS_LD2 : S_DS_LD3;
`endif
      end
`ifdef DOUBLE_STEP_EN
      S_DS_LD2: begin
        is_action    = 1'b1;
        rp_sel       = 2'd2;
        rp_rnotch    = ds_pos2;
        after_action = S_DS_LD3;
      end
      S_DS_LD3: begin
        is_action    = 1'b1;
        rp_sel       = 2'd3;
        rp_rnotch    = ds_pos3;
        after_action = S_SETTLE;
      end
`endif
      S_SETTLE: begin
        if (settle_cnt == 8'd0) next_state = S_ENC;
      end
      S_ENC: begin
        enc_valid  = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        if (cfg_accept)      next_state = S_CFG_CLR;
        else if (key_accept) next_state = S_STEP;
      end
    endcase
    if (is_action) begin
      if (state == S_STEP) rp_step = (phase == PH_HI);
      else                 rp_ld   = (phase == PH_HI);
      case (phase)
        PH_SETUP: next_phase = PH_HI;
        PH_HI:    next_phase = PH_LO;
        default: begin
          next_phase = PH_SETUP;
          next_state = after_action;
        end
      endcase
    end
  end

endmodule
